// File: rtl/id_stage_pkg.sv
// Shared RV32I decode definitions: widths, opcodes, internal ALU op codes
// and the ID/EX bundle layout used by the decode stage.
package id_stage_pkg;

    localparam int XLEN    = 32;
    localparam int ALUOP_W = 5;
    localparam int REG_AW  = 5;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    typedef enum logic [ALUOP_W-1:0] {
        ALU_NOP = 5'd0,
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR,  ALU_AND,
        ALU_BEQ, ALU_BNE, ALU_BLT, ALU_BGE, ALU_BLTU, ALU_BGEU,
        ALU_JAL, ALU_JALR,
        ALU_LB,  ALU_LH,  ALU_LW,  ALU_LBU, ALU_LHU,
        ALU_SB,  ALU_SH,  ALU_SW
    } aluop_e;

    typedef enum logic [2:0] {
        IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
    } imm_fmt_e;

    typedef enum logic [1:0] {
        OP1_ZERO, OP1_RS1, OP1_PC
    } op1_sel_e;

    typedef struct packed {
        logic                valid;
        logic [XLEN-1:0]     pc;
        logic [ALUOP_W-1:0]  aluop;
        logic [XLEN-1:0]     op1;
        logic [XLEN-1:0]     op2;
        logic [XLEN-1:0]     rs2val;
        logic [XLEN-1:0]     imm;
        logic                we;
        logic [REG_AW-1:0]   waddr;
        logic                illegal;
    } id_ex_t;

    function automatic imm_fmt_e imm_fmt(input logic [6:0] opcode);
        case (opcode)
            OPC_LOAD, OPC_OP_IMM, OPC_JALR: imm_fmt = IMM_I;
            OPC_STORE:                      imm_fmt = IMM_S;
            OPC_BRANCH:                     imm_fmt = IMM_B;
            OPC_LUI, OPC_AUIPC:             imm_fmt = IMM_U;
            OPC_JAL:                        imm_fmt = IMM_J;
            default:                        imm_fmt = IMM_NONE;
        endcase
    endfunction

    // alt selects SUB/SRA; OP-IMM callers must only pass it for shifts.
    function automatic aluop_e alu_from_f3(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  alu_from_f3 = alt ? ALU_SUB : ALU_ADD;
            3'b001:  alu_from_f3 = ALU_SLL;
            3'b010:  alu_from_f3 = ALU_SLT;
            3'b011:  alu_from_f3 = ALU_SLTU;
            3'b100:  alu_from_f3 = ALU_XOR;
            3'b101:  alu_from_f3 = alt ? ALU_SRA : ALU_SRL;
            3'b110:  alu_from_f3 = ALU_OR;
            default: alu_from_f3 = ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/id_stage_if.sv
// ID/EX handoff: the registered decode bundle towards EX and EX's accept signal.
interface id_stage_if;

    logic                                ex_ready;
    logic                                id_valid;
    logic [id_stage_pkg::XLEN-1:0]       id_pc;
    logic [id_stage_pkg::ALUOP_W-1:0]    id_aluop;
    logic [id_stage_pkg::XLEN-1:0]       id_op1;
    logic [id_stage_pkg::XLEN-1:0]       id_op2;
    logic [id_stage_pkg::XLEN-1:0]       id_rs2val;
    logic [id_stage_pkg::XLEN-1:0]       id_imm;
    logic                                id_we;
    logic [id_stage_pkg::REG_AW-1:0]     id_waddr;
    logic                                id_illegal;

    modport master (
        input  ex_ready,
        output id_valid, id_pc, id_aluop, id_op1, id_op2, id_rs2val,
               id_imm, id_we, id_waddr, id_illegal
    );

    modport slave (
        output ex_ready,
        input  id_valid, id_pc, id_aluop, id_op1, id_op2, id_rs2val,
               id_imm, id_we, id_waddr, id_illegal
    );

endinterface

// File: rtl/id_stage_imm_gen.sv
// Combinational RV32I immediate extraction; the format is chosen from the opcode.
module id_stage_imm_gen
    import id_stage_pkg::*;
(
    input  logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] imm
);

    always_comb begin
        imm = '0;
        case (imm_fmt(inst[6:0]))
            IMM_I: imm = {{20{inst[31]}}, inst[31:20]};
            IMM_S: imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            IMM_B: imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            IMM_U: imm = {inst[31:12], 12'b0};
            IMM_J: imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: decode, EX/MEM operand forwarding, load-use detection
// and the ID/EX pipeline register.
module id_stage
    import id_stage_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              if_valid,
    input  logic [XLEN-1:0]   if_pc,
    input  logic [XLEN-1:0]   if_inst,
    output logic              re1,
    output logic              re2,
    output logic [REG_AW-1:0] raddr1,
    output logic [REG_AW-1:0] raddr2,
    input  logic [XLEN-1:0]   rdata1,
    input  logic [XLEN-1:0]   rdata2,
    input  logic              ex_we,
    input  logic [REG_AW-1:0] ex_waddr,
    input  logic [XLEN-1:0]   ex_wdata,
    input  logic              ex_is_load,
    input  logic              mem_we,
    input  logic [REG_AW-1:0] mem_waddr,
    input  logic [XLEN-1:0]   mem_wdata,
    input  logic              flush,
    output logic              stall_req,
    id_stage_if.master        idex
);

    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic [REG_AW-1:0] rs1, rs2, rd;
    logic [XLEN-1:0]   imm;
    op1_sel_e          op1_sel;
    logic              op2_imm;
    logic              rd_wr;
    logic              illegal;
    aluop_e            aluop;
    logic              load_use;
    id_ex_t            dec, bundle_d, bundle_q;

    assign opcode = if_inst[6:0];
    assign funct3 = if_inst[14:12];
    assign rd     = if_inst[11:7];
    assign rs1    = if_inst[19:15];
    assign rs2    = if_inst[24:20];
    assign raddr1 = rs1;
    assign raddr2 = rs2;

    id_stage_imm_gen u_imm_gen (
        .inst (if_inst),
        .imm  (imm)
    );

    always_comb begin
        re1     = 1'b0;
        re2     = 1'b0;
        op1_sel = OP1_RS1;
        op2_imm = 1'b1;
        rd_wr   = 1'b0;
        illegal = 1'b0;
        aluop   = ALU_NOP;
        unique case (opcode)
            OPC_LUI:   begin op1_sel = OP1_ZERO; aluop = ALU_ADD; rd_wr = 1'b1; end
            OPC_AUIPC: begin op1_sel = OP1_PC;   aluop = ALU_ADD; rd_wr = 1'b1; end
            OPC_JAL:   begin op1_sel = OP1_PC;   aluop = ALU_JAL; rd_wr = 1'b1; end
            OPC_JALR:  begin re1 = 1'b1; aluop = ALU_JALR; rd_wr = 1'b1; end
            OPC_BRANCH: begin
                re1 = 1'b1; re2 = 1'b1; op2_imm = 1'b0;
                case (funct3)
                    3'b000:  aluop = ALU_BEQ;
                    3'b001:  aluop = ALU_BNE;
                    3'b100:  aluop = ALU_BLT;
                    3'b101:  aluop = ALU_BGE;
                    3'b110:  aluop = ALU_BLTU;
                    3'b111:  aluop = ALU_BGEU;
                    default: aluop = ALU_NOP;
                endcase
            end
            OPC_LOAD: begin
                re1 = 1'b1; rd_wr = 1'b1;
                case (funct3)
                    3'b000:  aluop = ALU_LB;
                    3'b001:  aluop = ALU_LH;
                    3'b010:  aluop = ALU_LW;
                    3'b100:  aluop = ALU_LBU;
                    3'b101:  aluop = ALU_LHU;
                    default: aluop = ALU_NOP;
                endcase
            end
            OPC_STORE: begin
                re1 = 1'b1; re2 = 1'b1;
                case (funct3)
                    3'b000:  aluop = ALU_SB;
                    3'b001:  aluop = ALU_SH;
                    3'b010:  aluop = ALU_SW;
                    default: aluop = ALU_NOP;
                endcase
            end
            // inst[30] is part of the immediate for ADDI, so it only matters for shifts.
            OPC_OP_IMM: begin
                re1 = 1'b1; rd_wr = 1'b1;
                aluop = alu_from_f3(funct3, if_inst[30] & (funct3 == 3'b101));
            end
            OPC_OP: begin
                re1 = 1'b1; re2 = 1'b1; op2_imm = 1'b0; rd_wr = 1'b1;
                aluop = alu_from_f3(funct3, if_inst[30]);
            end
            OPC_MISC_MEM, OPC_SYSTEM: aluop = ALU_NOP;
            default: illegal = 1'b1;
        endcase
    end

    // Per-port forwarding: x0 is hard zero, EX beats MEM, the regfile covers WB.
    logic [REG_AW-1:0] rs_addr  [2];
    logic [XLEN-1:0]   rs_rdata [2];
    logic [XLEN-1:0]   fwd_val  [2];

    assign rs_addr[0]  = rs1;
    assign rs_addr[1]  = rs2;
    assign rs_rdata[0] = rdata1;
    assign rs_rdata[1] = rdata2;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            assign fwd_val[gi] =
                (rs_addr[gi] == '0)                                   ? '0        :
                (ex_we && !ex_is_load && (ex_waddr == rs_addr[gi]))   ? ex_wdata  :
                (mem_we && (mem_waddr == rs_addr[gi]))                ? mem_wdata :
                                                                        rs_rdata[gi];
        end
    endgenerate

    assign load_use = if_valid && ex_we && ex_is_load && (ex_waddr != '0) &&
                      ((re1 && (ex_waddr == rs1)) || (re2 && (ex_waddr == rs2)));

    assign stall_req = !rdy || (!flush && (load_use || !idex.ex_ready));

    always_comb begin
        dec         = '0;
        dec.valid   = 1'b1;
        dec.pc      = if_pc;
        dec.aluop   = aluop;
        case (op1_sel)
            OP1_RS1: dec.op1 = fwd_val[0];
            OP1_PC:  dec.op1 = if_pc;
            default: dec.op1 = '0;
        endcase
        dec.op2     = op2_imm ? imm : fwd_val[1];
        dec.rs2val  = re2 ? fwd_val[1] : '0;
        dec.imm     = imm;
        dec.we      = rd_wr && (rd != '0) && !illegal;
        dec.waddr   = rd;
        dec.illegal = illegal;
    end

    // flush overrides a stalled EX: the wrong-path bundle must never reach it.
    always_comb begin
        bundle_d = bundle_q;
        if (rdy) begin
            if (flush)
                bundle_d = '0;
            else if (!idex.ex_ready)
                bundle_d = bundle_q;
            else if (load_use || !if_valid)
                bundle_d = '0;
            else
                bundle_d = dec;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            bundle_q <= '0;
        else
            bundle_q <= bundle_d;
    end

    assign idex.id_valid   = bundle_q.valid;
    assign idex.id_pc      = bundle_q.pc;
    assign idex.id_aluop   = bundle_q.aluop;
    assign idex.id_op1     = bundle_q.op1;
    assign idex.id_op2     = bundle_q.op2;
    assign idex.id_rs2val  = bundle_q.rs2val;
    assign idex.id_imm     = bundle_q.imm;
    assign idex.id_we      = bundle_q.we;
    assign idex.id_waddr   = bundle_q.waddr;
    assign idex.id_illegal = bundle_q.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Directed-vector bench for id_stage with hand-computed expectations.
module tb_id_stage;
    import id_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst, rdy, if_valid;
    logic [31:0] if_pc, if_inst;
    logic        re1, re2;
    logic [4:0]  raddr1, raddr2;
    logic [31:0] rdata1, rdata2;
    logic        ex_we, ex_is_load, mem_we, flush, stall_req;
    logic [4:0]  ex_waddr, mem_waddr;
    logic [31:0] ex_wdata, mem_wdata;

    int checks = 0;
    int errors = 0;

    id_stage_if idex();

    id_stage dut (
        .clk        (clk),
        .rst        (rst),
        .rdy        (rdy),
        .if_valid   (if_valid),
        .if_pc      (if_pc),
        .if_inst    (if_inst),
        .re1        (re1),
        .re2        (re2),
        .raddr1     (raddr1),
        .raddr2     (raddr2),
        .rdata1     (rdata1),
        .rdata2     (rdata2),
        .ex_we      (ex_we),
        .ex_waddr   (ex_waddr),
        .ex_wdata   (ex_wdata),
        .ex_is_load (ex_is_load),
        .mem_we     (mem_we),
        .mem_waddr  (mem_waddr),
        .mem_wdata  (mem_wdata),
        .flush      (flush),
        .stall_req  (stall_req),
        .idex       (idex)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        rdy = 1'b1; flush = 1'b0; idex.ex_ready = 1'b1;
        ex_we = 1'b0; ex_is_load = 1'b0; ex_waddr = '0; ex_wdata = '0;
        mem_we = 1'b0; mem_waddr = '0; mem_wdata = '0;
        rdata1 = '0; rdata2 = '0;
    endtask

    task automatic issue(input string name, input logic [31:0] pc, input logic [31:0] inst);
        if_valid = 1'b1; if_pc = pc; if_inst = inst;
        $display("txn %-12s pc=%h inst=%h", name, pc, inst);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; if_valid = 1'b0; if_pc = '0; if_inst = '0;
        idle();
        #1;
        check("rst_valid", idex.id_valid, 0);
        check("rst_op1",   idex.id_op1,   0);
        check("rst_we",    idex.id_we,    0);
        check("rst_pc",    idex.id_pc,    0);

        issue("addi_in_rst", 32'h100, 32'h0070_0293);
        tick();
        check("rst_hold_valid", idex.id_valid, 0);
        rst = 1'b1;

        issue("addi", 32'h100, 32'h0070_0293);
        #1;
        check("addi_re1",   re1,       1);
        check("addi_ra1",   raddr1,    0);
        check("addi_stall", stall_req, 0);
        tick();
        check("addi_valid", idex.id_valid, 1);
        check("addi_op1",   idex.id_op1,   0);
        check("addi_op2",   idex.id_op2,   7);
        check("addi_imm",   idex.id_imm,   7);
        check("addi_waddr", idex.id_waddr, 5);
        check("addi_we",    idex.id_we,    1);
        check("addi_pc",    idex.id_pc,    32'h100);
        check("addi_aluop", idex.id_aluop, ALU_ADD);

        issue("add_fwd", 32'h104, 32'h0020_81B3);
        ex_we = 1; ex_waddr = 1; ex_wdata = 32'h11;
        mem_we = 1; mem_waddr = 2; mem_wdata = 32'h22;
        rdata1 = 32'hFF; rdata2 = 32'hFF;
        #1;
        check("add_ra1", raddr1, 1);
        check("add_ra2", raddr2, 2);
        check("add_re2", re2,    1);
        tick();
        check("add_op1",    idex.id_op1,    32'h11);
        check("add_op2",    idex.id_op2,    32'h22);
        check("add_rs2val", idex.id_rs2val, 32'h22);
        check("add_waddr",  idex.id_waddr,  3);

        issue("add_prio", 32'h108, 32'h0020_81B3);
        ex_waddr = 2; ex_wdata = 32'h33; mem_waddr = 2; mem_wdata = 32'h44;
        tick();
        check("prio_op1", idex.id_op1, 32'hFF);
        check("prio_op2", idex.id_op2, 32'h33);

        issue("add_x0", 32'h10C, 32'h0020_01B3);
        ex_waddr = 0; ex_wdata = 32'h99; mem_waddr = 0; mem_wdata = 32'h77;
        tick();
        check("x0_op1", idex.id_op1, 0);
        check("x0_op2", idex.id_op2, 32'hFF);

        idle();
        issue("lui", 32'h110, 32'h1234_53B7);
        ex_we = 1; ex_is_load = 1; ex_waddr = 8;
        #1;
        check("lui_re1",   re1,       0);
        check("lui_stall", stall_req, 0);
        tick();
        check("lui_op1", idex.id_op1, 0);
        check("lui_op2", idex.id_op2, 32'h1234_5000);
        check("lui_we",  idex.id_we,  1);

        idle();
        issue("jal", 32'h200, 32'h0010_00EF);
        #1;
        check("jal_re1", re1, 0);
        check("jal_re2", re2, 0);
        tick();
        check("jal_op1",   idex.id_op1,   32'h200);
        check("jal_imm",   idex.id_imm,   32'h800);
        check("jal_aluop", idex.id_aluop, ALU_JAL);
        check("jal_we",    idex.id_we,    1);

        issue("beq", 32'h204, 32'hFE20_8EE3);
        rdata1 = 32'hA; rdata2 = 32'hB;
        tick();
        check("beq_imm",   idex.id_imm,   32'hFFFF_FFFC);
        check("beq_op1",   idex.id_op1,   32'hA);
        check("beq_op2",   idex.id_op2,   32'hB);
        check("beq_we",    idex.id_we,    0);
        check("beq_aluop", idex.id_aluop, ALU_BEQ);

        issue("sw", 32'h208, 32'h0020_A423);
        tick();
        check("sw_imm",    idex.id_imm,    8);
        check("sw_op2",    idex.id_op2,    8);
        check("sw_rs2val", idex.id_rs2val, 32'hB);
        check("sw_we",     idex.id_we,     0);
        check("sw_aluop",  idex.id_aluop,  ALU_SW);

        idle();
        issue("load_use", 32'h300, 32'h0020_81B3);
        ex_we = 1; ex_is_load = 1; ex_waddr = 1;
        rdata1 = 32'hFF; rdata2 = 32'hFF;
        #1;
        check("lu_stall", stall_req, 1);
        tick();
        check("lu_bubble_valid", idex.id_valid, 0);
        check("lu_bubble_we",    idex.id_we,    0);
        ex_we = 0; ex_is_load = 0; ex_waddr = 0;
        mem_we = 1; mem_waddr = 1; mem_wdata = 32'h55;
        $display("txn %-12s pc=%h inst=%h", "lu_replay", if_pc, if_inst);
        #1;
        check("lu_clear_stall", stall_req, 0);
        tick();
        check("lu_valid", idex.id_valid, 1);
        check("lu_op1",   idex.id_op1,   32'h55);
        check("lu_op2",   idex.id_op2,   32'hFF);
        check("lu_pc",    idex.id_pc,    32'h300);

        idle();
        issue("lu_rs2", 32'h304, 32'h0020_81B3);
        ex_we = 1; ex_is_load = 1; ex_waddr = 2;
        #1;
        check("lu_rs2_stall", stall_req, 1);

        idle();
        issue("ex_busy", 32'h304, 32'h0070_0293);
        idex.ex_ready = 1'b0;
        #1;
        check("busy_stall", stall_req, 1);
        tick();
        check("busy_pc",    idex.id_pc,    32'h300);
        check("busy_valid", idex.id_valid, 1);
        check("busy_op1",   idex.id_op1,   32'h55);

        issue("flush", 32'h308, 32'h0020_81B3);
        ex_we = 1; ex_is_load = 1; ex_waddr = 1; flush = 1;
        #1;
        check("flush_stall", stall_req, 0);
        tick();
        check("flush_valid", idex.id_valid, 0);

        idle();
        issue("pre_rdy", 32'h400, 32'h0070_0293);
        tick();
        check("pre_rdy_valid", idex.id_valid, 1);
        issue("rdy_low", 32'h404, 32'h0010_00EF);
        rdy = 0; flush = 1;
        #1;
        check("rdy_stall", stall_req, 1);
        tick();
        check("rdy_pc",    idex.id_pc,    32'h400);
        check("rdy_valid", idex.id_valid, 1);

        idle();
        if_valid = 1'b0;
        $display("txn %-12s pc=%h inst=%h", "if_invalid", if_pc, if_inst);
        tick();
        check("ifv_valid", idex.id_valid, 0);

        issue("illegal", 32'h500, 32'h0000_02FF);
        tick();
        check("ill_valid", idex.id_valid,   1);
        check("ill_flag",  idex.id_illegal, 1);
        check("ill_we",    idex.id_we,      0);

        issue("addi_x0", 32'h504, 32'h0010_0013);
        tick();
        check("x0rd_valid", idex.id_valid,   1);
        check("x0rd_we",    idex.id_we,      0);
        check("x0rd_ill",   idex.id_illegal, 0);

        issue("addi_neg", 32'h508, 32'hFFF0_0293);
        tick();
        check("neg_imm",   idex.id_imm,   32'hFFFF_FFFF);
        check("neg_aluop", idex.id_aluop, ALU_ADD);
        check("neg_valid", idex.id_valid, 1);

        #2;
        rst = 1'b0;
        $display("txn %-12s pc=%h inst=%h", "async_rst", if_pc, if_inst);
        #1;
        check("arst_valid", idex.id_valid, 0);
        check("arst_pc",    idex.id_pc,    0);
        tick();
        rst = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
